calc_stream_io: RTL and testbench

- Streaming front/back end for the 3x3 matrix Calculator stage, which has 144-bit A, B and Result buses, each holding nine 16-bit elements with element 0 at [143:128].
- Accepts 18 operand words over a valid/ready input stream: nine words of A, then nine words of B.
- Presents the assembled A and B buses to the Calculator and waits a fixed number of cycles.
- Captures Result, then returns it as nine words over a valid/ready output stream.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/calc_word_packer.sv | 37 +++
 rtl/calc_stream_io.sv | 146 ++++++++++++++
 tb/tb_calc_stream_io.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared constants, FSM state type and element-slice helper for calc_stream_io.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

  localparam int ELEM_W = 16;
  localparam int N_ELEM = 9;
  localparam int BUS_W  = ELEM_W * N_ELEM;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    WAIT,
    SEND
  } state_t;

  // MSB bit index of element idx; element 0 occupies the top of the bus.
  function automatic int elem_slice(input int idx,
                                    input int elem_w = ELEM_W,
                                    input int n_elem = N_ELEM);
    return elem_w * (n_elem - idx) - 1;
  endfunction

endpackage

// File: rtl/calc_word_packer.sv
// calc_word_packer: writes one word into slot i_idx of a bus register (slot 0 = MSB element).
// Latency: 1 cycle from i_en to o_bus.
// Backpressure: none; the register holds its contents until the next write.
// Ports: clk, rst_n (async active-low clear), i_en write strobe, i_idx slot,
//        i_word data, o_bus assembled bus.
module calc_word_packer
  import calc_pkg::*;
#(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_en,
  input  logic [$clog2(N_ELEM)-1:0]  i_idx,
  input  logic [ELEM_W-1:0]          i_word,
  output logic [ELEM_W*N_ELEM-1:0]   o_bus
);

  localparam int SEL_W = $clog2(ELEM_W * N_ELEM);

  logic [ELEM_W*N_ELEM-1:0] r_bus;
  logic [SEL_W-1:0]         w_sel;

  assign w_sel = SEL_W'(elem_slice(int'(i_idx), ELEM_W, N_ELEM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus <= '0;
    end else if (i_en) begin
      r_bus[w_sel -: ELEM_W] <= i_word;
    end
  end

  assign o_bus = r_bus;

endmodule

// File: rtl/calc_stream_io.sv
// calc_stream_io: streams 9 A + 9 B words into the Calculator buses, waits, returns 9 result words.
// Latency: out_valid rises CALC_LAT+1 edges after the edge accepting the 18th operand word.
// Backpressure: in_ready low outside LOAD_A/LOAD_B; out_data/out_valid hold while out_ready is low.
// Ports: in_data/in_valid/in_ready operand stream; calc_a/calc_b/calc_result Calculator buses;
//        out_data/out_valid/out_ready result stream; busy high while an operation is in flight.
module calc_stream_io
  import calc_pkg::*;
#(
  parameter int ELEM_W   = 16,
  parameter int N_ELEM   = 9,
  parameter int CALC_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ELEM_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ELEM_W*N_ELEM-1:0]  calc_a,
  output logic [ELEM_W*N_ELEM-1:0]  calc_b,
  input  logic [ELEM_W*N_ELEM-1:0]  calc_result,
  output logic [ELEM_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int IDX_W     = $clog2(N_ELEM);
  localparam int CNT_W     = $clog2(CALC_LAT) + 1;
  localparam int BUS_BITS  = ELEM_W * N_ELEM;
  localparam int SEL_W     = $clog2(BUS_BITS);

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [BUS_BITS-1:0]  r_res;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [ELEM_W-1:0]    r_out_data;
  logic                 r_busy;

  logic                 w_in_fire;
  logic                 w_last;
  logic                 w_wr_a;
  logic                 w_wr_b;
  logic [SEL_W-1:0]     w_sel_cur;
  logic [SEL_W-1:0]     w_sel_nxt;

  assign w_in_fire = in_valid && r_in_ready;
  assign w_last    = (r_idx == IDX_W'(N_ELEM - 1));
  assign w_wr_a    = w_in_fire && (r_state == LOAD_A);
  assign w_wr_b    = w_in_fire && (r_state == LOAD_B);
  assign w_sel_cur = SEL_W'(elem_slice(int'(r_idx), ELEM_W, N_ELEM));
  assign w_sel_nxt = SEL_W'(elem_slice(int'(r_idx) + 1, ELEM_W, N_ELEM));

  calc_word_packer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_pack_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_wr_a),
    .i_idx  (r_idx),
    .i_word (in_data),
    .o_bus  (calc_a)
  );

  calc_word_packer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_pack_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_wr_b),
    .i_idx  (r_idx),
    .i_word (in_data),
    .o_bus  (calc_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD_A;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          // Also raises in_ready on the first edge after reset release.
          r_in_ready <= 1'b1;
          r_busy     <= w_in_fire || (r_idx != '0);
          if (w_in_fire) begin
            if (w_last) begin
              r_idx   <= '0;
              r_state <= LOAD_B;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (w_in_fire) begin
            if (w_last) begin
              r_idx      <= '0;
              r_cnt      <= CNT_W'(CALC_LAT - 1);
              r_in_ready <= 1'b0;
              r_state    <= WAIT;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_res   <= calc_result;
            r_state <= SEND;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        SEND: begin
          // First SEND cycle primes the output register from res_q element 0.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_res[w_sel_cur -: ELEM_W];
          end else if (out_ready) begin
            if (w_last) begin
              r_idx       <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= LOAD_A;
            end else begin
              r_idx      <= r_idx + IDX_W'(1);
              r_out_data <= r_res[w_sel_nxt -: ELEM_W];
            end
          end
        end
        default: r_state <= LOAD_A;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_calc_stream_io.sv
module tb_calc_stream_io;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  in_data     [2];
  logic         in_valid    [2];
  logic         in_ready    [2];
  logic [143:0] calc_a      [2];
  logic [143:0] calc_b      [2];
  logic [143:0] calc_result [2];
  logic [15:0]  out_data    [2];
  logic         out_valid   [2];
  logic         out_ready   [2];
  logic         busy        [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0 runs with CALC_LAT=1, instance 1 with CALC_LAT=4.
  calc_stream_io #(.ELEM_W(16), .N_ELEM(9), .CALC_LAT(1)) dut_lat1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .calc_a(calc_a[0]), .calc_b(calc_b[0]),
    .calc_result(calc_result[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .busy(busy[0]));

  calc_stream_io #(.ELEM_W(16), .N_ELEM(9), .CALC_LAT(4)) dut_lat4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .calc_a(calc_a[1]), .calc_b(calc_b[1]),
    .calc_result(calc_result[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .busy(busy[1]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks an operation as counts: words accepted, edges since the last operand,
  // result words delivered.
  int          m_started [2];
  int          m_acc     [2];
  int          m_t       [2];
  int          m_sent    [2];
  logic [15:0] m_a   [2][9];
  logic [15:0] m_b   [2][9];
  logic [15:0] m_res [2][9];

  always @(posedge clk or negedge rst_n) begin : model
    bit vld;
    logic [143:0] r;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_started[k] = 0; m_acc[k] = 0; m_t[k] = 0; m_sent[k] = 0;
        for (int i = 0; i < 9; i++) begin
          m_a[k][i] = '0; m_b[k][i] = '0; m_res[k][i] = '0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_started[k] == 0) begin
          m_started[k] = 1;
        end else if (m_acc[k] < 18) begin
          if (in_valid[k]) begin
            if (m_acc[k] < 9) m_a[k][m_acc[k]] = in_data[k];
            else              m_b[k][m_acc[k]-9] = in_data[k];
            m_acc[k]++;
            m_t[k] = 0;
          end
        end else begin
          vld = (m_t[k] >= lat_of(k) + 1) && (m_sent[k] < 9);
          if (m_t[k] < 1000) m_t[k]++;
          if (m_t[k] == lat_of(k)) begin
            r = calc_result[k];
            for (int i = 0; i < 9; i++) begin
              m_res[k][i] = r[143:128];
              r = r << 16;
            end
          end
          if (vld && out_ready[k]) begin
            m_sent[k]++;
            if (m_sent[k] == 9) begin
              m_acc[k] = 0; m_sent[k] = 0; m_t[k] = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin : compare
    logic [143:0] ea, eb;
    bit ev;
    for (int k = 0; k < 2; k++) begin
      ea = '0; eb = '0;
      for (int i = 0; i < 9; i++) begin
        ea = {ea[127:0], m_a[k][i]};
        eb = {eb[127:0], m_b[k][i]};
      end
      ev = (m_acc[k] == 18) && (m_t[k] >= lat_of(k) + 1) && (m_sent[k] < 9);
      chk($sformatf("calc_a%0d", k), calc_a[k], ea);
      chk($sformatf("calc_b%0d", k), calc_b[k], eb);
      chk($sformatf("in_ready%0d", k), 144'(in_ready[k]),
          144'((m_started[k] != 0) && (m_acc[k] < 18)));
      chk($sformatf("out_valid%0d", k), 144'(out_valid[k]), 144'(ev));
      chk($sformatf("busy%0d", k), 144'(busy[k]), 144'(m_acc[k] != 0));
      if (ev) chk($sformatf("out_data%0d", k), 144'(out_data[k]), 144'(m_res[k][m_sent[k]]));
    end
  end

  // Length of the most recent run of in_ready high on instance 0.
  int rdy_run = 0;
  int rdy_last = 0;
  always @(negedge clk) begin
    if (in_ready[0]) rdy_run++;
    else begin
      if (rdy_run > 0) rdy_last = rdy_run;
      rdy_run = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_words(input int k, input logic [15:0] w[18], input int n, input bit gaps);
    bit acc;
    int guard;
    int g;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          in_valid[k] = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_data[k] = w[i];
      in_valid[k] = 1'b1;
      guard = 0;
      do begin
        @(posedge clk);
        acc = in_ready[k];
        #1;
        guard++;
      end while (!acc && guard < 100);
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_timeout%0d: word %0d not accepted, expected accept within 100 cycles", k, i);
        in_valid[k] = 1'b0;
        return;
      end
    end
    in_valid[k] = 1'b0;
  endtask

  // Waits for out_valid (returns edge count), then collects nine words.
  task automatic recv(input int k, input bit stall, input logic [143:0] exp,
                      output int lat, output logic [143:0] got);
    int n;
    int cnt;
    bit fire;
    logic [15:0] d;
    logic [143:0] sh;
    out_ready[k] = 1'b1;
    lat = 0; got = '0; cnt = 0; n = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid[k] && lat < 50);
    in_valid[k] = 1'b0;
    if (!out_valid[k]) begin
      checks++; errors++;
      $display("FAIL recv_timeout%0d: out_valid low, expected high within 50 cycles", k);
      return;
    end
    while (cnt < 9 && n < 200) begin
      out_ready[k] = stall ? (n % 3 == 0) : 1'b1;
      @(posedge clk);
      fire = out_valid[k] && out_ready[k];
      d = out_data[k];
      #1;
      n++;
      if (fire) begin
        got = {got[127:0], d};
        cnt++;
      end else begin
        sh = exp >> (16 * (8 - cnt));
        chk($sformatf("stall_hold%0d", k), 144'(out_data[k]), 144'(sh[15:0]));
      end
    end
    if (cnt < 9) begin
      checks++; errors++;
      $display("FAIL recv_count%0d: got %0d words, expected 9", k, cnt);
    end
    out_ready[k] = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  localparam logic [143:0] A_1_9   = 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009;
  localparam logic [143:0] B_VEC   = 144'h0007_0003_0005_000c_000b_0011_0014_0003_0000;
  localparam logic [143:0] RES_1   = 144'h0011_0022_0033_0044_0055_0066_0077_0088_0099;
  localparam logic [143:0] RES_2   = 144'ha001_a002_a003_a004_a005_a006_a007_a008_a009;
  localparam logic [143:0] A_NEW   = 144'h0100_0101_0102_0103_0104_0105_0106_0107_0108;
  localparam logic [143:0] B_NEW   = 144'h0200_0201_0202_0203_0204_0205_0206_0207_0208;
  localparam logic [143:0] RES_OLD = 144'hbad0_bad1_bad2_bad3_bad4_bad5_bad6_bad7_bad8;
  localparam logic [143:0] RES_NEW = 144'h0f01_0f02_0f03_0f04_0f05_0f06_0f07_0f08_0f09;

  initial begin : main
    logic [15:0]  wa [18];
    logic [15:0]  wn [18];
    logic [143:0] got;
    int lat;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0; calc_result[k] = '0;
    end
    wa = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9,
           16'd7, 16'd3, 16'd5, 16'd12, 16'd11, 16'd17, 16'd20, 16'd3, 16'd0};
    for (int i = 0; i < 9; i++) begin
      wn[i]   = 16'h0100 + 16'(i);
      wn[i+9] = 16'h0200 + 16'(i);
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 144'(in_ready[0]), 144'(0));
    chk("rst_out_valid", 144'(out_valid[0]), 144'(0));
    chk("rst_calc_a", calc_a[0], 144'h0);
    rst_n = 1'b1;

    // Gap-free load and result return, CALC_LAT=1
    calc_result[0] = RES_1;
    out_ready[0] = 1'b1;
    send_words(0, wa, 18, 1'b0);
    chk("load_calc_a", calc_a[0], A_1_9);
    chk("load_calc_b", calc_b[0], B_VEC);
    recv(0, 1'b0, RES_1, lat, got);
    chk("lat1_rise_edges", 144'(lat), 144'(2));
    chk("lat1_words", got, RES_1);
    chk("in_ready_return", 144'(in_ready[0]), 144'(1));
    chk("in_ready_run", 144'(rdy_last), 144'(18));

    // Input gaps, in_valid during WAIT/SEND, output backpressure
    calc_result[0] = RES_2;
    send_words(0, wa, 18, 1'b1);
    chk("gap_calc_a", calc_a[0], A_1_9);
    chk("gap_calc_b", calc_b[0], B_VEC);
    in_data[0] = 16'hdead;
    in_valid[0] = 1'b1;
    recv(0, 1'b1, RES_2, lat, got);
    chk("stall_words", got, RES_2);
    chk("ignored_in_a", calc_a[0], A_1_9);

    // Reset in the middle of a load
    send_words(0, wa, 12, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_calc_a", calc_a[0], 144'h0);
    chk("midrst_calc_b", calc_b[0], 144'h0);
    chk("midrst_in_ready", 144'(in_ready[0]), 144'(0));
    chk("midrst_busy", 144'(busy[0]), 144'(0));
    chk("midrst_out_data", 144'(out_data[0]), 144'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_words(0, wn, 18, 1'b0);
    chk("fresh_calc_a", calc_a[0], A_NEW);
    chk("fresh_calc_b", calc_b[0], B_NEW);
    recv(0, 1'b0, RES_2, lat, got);
    chk("fresh_words", got, RES_2);

    // CALC_LAT=4: result changes after two WAIT cycles, the later value is sampled
    calc_result[1] = RES_OLD;
    send_words(1, wn, 18, 1'b0);
    fork
      recv(1, 1'b0, RES_NEW, lat, got);
      begin
        repeat (2) @(posedge clk);
        #1;
        calc_result[1] = RES_NEW;
      end
    join
    chk("lat4_rise_edges", 144'(lat), 144'(5));
    chk("lat4_words", got, RES_NEW);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 400000 time units");
    $fatal(1);
  end

endmodule
